// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back / write-allocate data cache controller.
// Answers the head-of-LSQ load/store in the same cycle on a hit; on a miss a
// blocking FSM writes back a dirty victim, fetches the block and waits for
// the tagged fill, after which the request hits on the following cycle.
//
// Ports:
//   clock, reset              system clock, synchronous active-high reset
//   lsq_is_requesting         request valid, held until completed
//   address/value             byte address and LSB-aligned store data
//   mem_size/is_store         0=BYTE 1=HALF 2=WORD, 1=store
//   completed/load_value      same-cycle completion and right-aligned load data
//   proc2mem_command/addr/data   memory request (0=NONE 1=LOAD 2=STORE)
//   mem2proc_response         nonzero = command accepted, value is its tag
//   mem2proc_data/tag         returning block and its tag (0 = none)
module dcache_ctrl #(
    parameter int unsigned LINES     = 32,
    parameter int unsigned MEM_TAG_W = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 lsq_is_requesting,
    input  logic [31:0]          address,
    input  logic [31:0]          value,
    input  logic [1:0]           mem_size,
    input  logic                 is_store,
    output logic                 completed,
    output logic [31:0]          load_value,
    output logic [1:0]           proc2mem_command,
    output logic [31:0]          proc2mem_addr,
    output logic [63:0]          proc2mem_data,
    input  logic [MEM_TAG_W-1:0] mem2proc_response,
    input  logic [63:0]          mem2proc_data,
    input  logic [MEM_TAG_W-1:0] mem2proc_tag
);
    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = 29 - IDX_W;

    localparam logic [1:0] CmdNone  = 2'd0;
    localparam logic [1:0] CmdLoad  = 2'd1;
    localparam logic [1:0] CmdStore = 2'd2;

    typedef enum logic [1:0] {StIdle, StWb, StFetch, StWait} state_e;

    state_e               state_q, state_d;
    logic [LINES-1:0]     valid_q, valid_d;
    logic [LINES-1:0]     dirty_q, dirty_d;
    logic [TAG_W-1:0]     tags_q [LINES];
    logic [TAG_W-1:0]     tags_d [LINES];
    logic [63:0]          data_q [LINES];
    logic [63:0]          data_d [LINES];
    // Index/tag of the missing request, frozen while the miss is serviced.
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [TAG_W-1:0]     rtag_q, rtag_d;
    logic [MEM_TAG_W-1:0] pend_q, pend_d;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [2:0]       sel_off;
    logic [5:0]       sel_sh;
    logic [63:0]      size_mask;
    logic [63:0]      sel_mask;
    logic [63:0]      line_data;
    logic [63:0]      merged;
    logic [31:0]      sel_word;
    logic             hit;

    assign req_idx = address[IDX_W+2:3];
    assign req_tag = address[31:IDX_W+3];

    // Sub-word position; low alignment bits are dropped for HALF/WORD.
    always_comb begin
        case (mem_size)
            2'd0: begin
                sel_off   = address[2:0];
                size_mask = 64'h0000_0000_0000_00FF;
            end
            2'd1: begin
                sel_off   = {address[2:1], 1'b0};
                size_mask = 64'h0000_0000_0000_FFFF;
            end
            default: begin
                sel_off   = {address[2], 2'b00};
                size_mask = 64'h0000_0000_FFFF_FFFF;
            end
        endcase
        sel_sh = {sel_off, 3'b000};
    end

    assign line_data = data_q[req_idx];
    assign sel_word  = 32'((line_data >> sel_sh) & size_mask);
    assign sel_mask  = size_mask << sel_sh;
    assign merged    = (line_data & ~sel_mask) | (({32'h0, value} << sel_sh) & sel_mask);
    assign hit       = lsq_is_requesting && valid_q[req_idx] && (tags_q[req_idx] == req_tag);

    always_comb begin
        state_d          = state_q;
        valid_d          = valid_q;
        dirty_d          = dirty_q;
        tags_d           = tags_q;
        data_d           = data_q;
        idx_d            = idx_q;
        rtag_d           = rtag_q;
        pend_d           = pend_q;
        completed        = 1'b0;
        load_value       = 32'h0;
        proc2mem_command = CmdNone;
        proc2mem_addr    = 32'h0;
        proc2mem_data    = 64'h0;

        unique case (state_q)
            StIdle: begin
                if (hit) begin
                    completed = 1'b1;
                    if (is_store) begin
                        data_d[req_idx]  = merged;
                        dirty_d[req_idx] = 1'b1;
                    end else begin
                        load_value = sel_word;
                    end
                end else if (lsq_is_requesting) begin
                    idx_d  = req_idx;
                    rtag_d = req_tag;
                    if (valid_q[req_idx] && dirty_q[req_idx]) begin
                        state_d = StWb;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StWb: begin
                proc2mem_command = CmdStore;
                proc2mem_addr    = {tags_q[idx_q], idx_q, 3'b000};
                proc2mem_data    = data_q[idx_q];
                if (mem2proc_response != '0) begin
                    dirty_d[idx_q] = 1'b0;
                    state_d        = StFetch;
                end
            end
            StFetch: begin
                proc2mem_command = CmdLoad;
                proc2mem_addr    = {rtag_q, idx_q, 3'b000};
                if (mem2proc_response != '0) begin
                    pend_d  = mem2proc_response;
                    state_d = StWait;
                end
            end
            StWait: begin
                // Fill completes even if the LSQ dropped the request meanwhile.
                if ((mem2proc_tag != '0) && (mem2proc_tag == pend_q)) begin
                    data_d[idx_q]  = mem2proc_data;
                    tags_d[idx_q]  = rtag_q;
                    valid_d[idx_q] = 1'b1;
                    dirty_d[idx_q] = 1'b0;
                    pend_d         = '0;
                    state_d        = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            valid_q <= '0;
            dirty_q <= '0;
            idx_q   <= '0;
            rtag_q  <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            tags_q  <= tags_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            rtag_q  <= rtag_d;
            pend_q  <= pend_d;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed vector table, hand-written
// miss/writeback/drop/reset sequences, then randomized accesses checked
// against an architectural byte-level memory model plus a tag-presence model.
module tb_dcache_ctrl;
    localparam int MEM_TAG_W = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        lsq_is_requesting = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] value = '0;
    logic [1:0]  mem_size = '0;
    logic        is_store = 1'b0;
    logic        completed;
    logic [31:0] load_value;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_response = '0;
    logic [63:0] mem2proc_data = '0;
    logic [3:0]  mem2proc_tag = '0;

    int checks = 0;
    int errors = 0;

    dcache_ctrl #(.LINES(32), .MEM_TAG_W(MEM_TAG_W)) dut (
        .clock             (clock),
        .reset             (reset),
        .lsq_is_requesting (lsq_is_requesting),
        .address           (address),
        .value             (value),
        .mem_size          (mem_size),
        .is_store          (is_store),
        .completed         (completed),
        .load_value        (load_value),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag)
    );

    always #5 clock = ~clock;

    // Architectural contents (what loads must see) and backing memory contents.
    logic [63:0] arch [logic [31:0]];
    logic [63:0] mem  [logic [31:0]];
    bit          cvalid [32];
    logic [23:0] ctag [32];

    function automatic logic [63:0] init_blk(input logic [31:0] blk);
        return {blk ^ 32'h5A5A_A5A5, blk * 32'h9E37_79B1};
    endfunction

    function automatic logic [63:0] arch_rd(input logic [31:0] blk);
        return arch.exists(blk) ? arch[blk] : init_blk(blk);
    endfunction

    function automatic logic [63:0] mem_rd(input logic [31:0] blk);
        return mem.exists(blk) ? mem[blk] : init_blk(blk);
    endfunction

    function automatic int base_of(input logic [31:0] a, input logic [1:0] sz);
        int off;
        off = int'(a[2:0]);
        if (sz == 2'd0) return off;
        if (sz == 2'd1) return off & 6;
        return off & 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz);
        logic [63:0] b;
        logic [31:0] r;
        int base;
        int n;
        b = arch_rd({a[31:3], 3'b000});
        base = base_of(a, sz);
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = b[8*(base+i) +: 8];
        return r;
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [1:0] sz,
                                        input logic [31:0] v);
        logic [63:0] b;
        int base;
        int n;
        b = arch_rd({a[31:3], 3'b000});
        base = base_of(a, sz);
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) b[8*(base+i) +: 8] = v[8*i +: 8];
        arch[{a[31:3], 3'b000}] = b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // One LSQ request driven until completion, with a randomized memory responder.
    task automatic access(input logic [31:0] a, input logic [1:0] sz, input bit st,
                          input logic [31:0] v, output logic [31:0] lv, output bit was_hit);
        int cyc;
        int fill_cyc;
        int delay;
        int idx;
        bit done;
        bit have_pend;
        bit exp_hit;
        logic [3:0]  ptag;
        logic [31:0] blk;
        logic [31:0] exp_lv;
        blk = {a[31:3], 3'b000};
        idx = int'(a[7:3]);
        exp_hit = cvalid[idx] && (ctag[idx] == a[31:8]);
        exp_lv = st ? 32'h0 : model_load(a, sz);
        @(negedge clock);
        lsq_is_requesting = 1'b1;
        address = a;
        mem_size = sz;
        is_store = st;
        value = v;
        cyc = 0;
        fill_cyc = -10;
        delay = 0;
        done = 1'b0;
        have_pend = 1'b0;
        ptag = '0;
        lv = '0;
        was_hit = 1'b0;
        while (!done && cyc < 200) begin
            mem2proc_response = '0;
            mem2proc_tag = '0;
            mem2proc_data = {$urandom, $urandom};
            #1;
            if (completed) begin
                done = 1'b1;
                lv = load_value;
                chk("hit_cmd_none", 64'(proc2mem_command), 64'd0);
            end else begin
                case (proc2mem_command)
                    2'd2: begin
                        chk("wb_data", proc2mem_data, arch_rd(proc2mem_addr));
                        mem2proc_tag = 4'($urandom_range(15, 0));
                        if ($urandom_range(1, 0) == 1) begin
                            mem2proc_response = 4'($urandom_range(15, 1));
                            mem[proc2mem_addr] = proc2mem_data;
                        end
                    end
                    2'd1: begin
                        chk("fetch_addr", 64'(proc2mem_addr), 64'(blk));
                        mem2proc_tag = 4'($urandom_range(15, 0));
                        if ($urandom_range(1, 0) == 1) begin
                            ptag = 4'($urandom_range(15, 1));
                            mem2proc_response = ptag;
                            have_pend = 1'b1;
                            delay = $urandom_range(3, 0);
                        end
                    end
                    2'd0: begin
                        if (have_pend) begin
                            if (delay == 0) begin
                                mem2proc_tag = ptag;
                                mem2proc_data = mem_rd(blk);
                                fill_cyc = cyc;
                                have_pend = 1'b0;
                            end else begin
                                delay--;
                                if ($urandom_range(1, 0) == 1)
                                    mem2proc_tag = (ptag == 4'd15) ? 4'd1 : ptag + 4'd1;
                            end
                        end
                    end
                    default: chk("cmd_legal", 64'(proc2mem_command), 64'd0);
                endcase
            end
            if (!done) begin
                @(negedge clock);
                cyc++;
            end
        end
        chk("complete_timeout", 64'(done), 64'd1);
        if (done) begin
            was_hit = (cyc == 0);
            chk("hit_vs_model", 64'(was_hit), 64'(exp_hit));
            if (!was_hit) chk("miss_latency", 64'(cyc), 64'(fill_cyc + 1));
            chk(st ? "store_lv_zero" : "load_data", 64'(lv), 64'(exp_lv));
            if (st) model_store(a, sz, v);
            cvalid[idx] = 1'b1;
            ctag[idx] = a[31:8];
        end
        @(negedge clock);
        lsq_is_requesting = 1'b0;
        mem2proc_response = '0;
        mem2proc_tag = '0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  sz;
        bit          st;
        logic [31:0] val;
        bit          hit;
        logic [31:0] lv;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [31:0] lv;
        bit h;
        logic [31:0] a;

        vecs[0]  = '{32'h0000_1004, 2'd2, 1'b0, 32'h0,         1'b0, 32'h89AB_CDEF};
        vecs[1]  = '{32'h0000_1007, 2'd0, 1'b0, 32'h0,         1'b1, 32'h0000_0089};
        vecs[2]  = '{32'h0000_1002, 2'd1, 1'b1, 32'h0000_BEEF, 1'b1, 32'h0};
        vecs[3]  = '{32'h0000_1000, 2'd2, 1'b0, 32'h0,         1'b1, 32'hBEEF_4567};
        vecs[4]  = '{32'h0000_2000, 2'd2, 1'b0, 32'h0,         1'b0, 32'h5566_7788};
        vecs[5]  = '{32'h0000_1006, 2'd1, 1'b0, 32'h0,         1'b0, 32'h0000_89AB};
        vecs[6]  = '{32'h0000_1003, 2'd1, 1'b0, 32'h0,         1'b1, 32'h0000_BEEF};
        vecs[7]  = '{32'h0000_1001, 2'd0, 1'b1, 32'hFFFF_FFA5, 1'b1, 32'h0};
        vecs[8]  = '{32'h0000_1003, 2'd2, 1'b0, 32'h0,         1'b1, 32'hBEEF_A567};
        vecs[9]  = '{32'h0000_1006, 2'd2, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0};
        vecs[10] = '{32'h0000_1004, 2'd2, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[11] = '{32'h0000_1000, 2'd0, 1'b0, 32'h0,         1'b1, 32'h0000_0067};

        mem[32'h1000]  = 64'h89AB_CDEF_0123_4567;
        arch[32'h1000] = 64'h89AB_CDEF_0123_4567;
        mem[32'h2000]  = 64'h1122_3344_5566_7788;
        arch[32'h2000] = 64'h1122_3344_5566_7788;
        for (int i = 0; i < 32; i++) begin
            cvalid[i] = 1'b0;
            ctag[i] = '0;
        end

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_completed", 64'(completed), 64'd0);
        chk("rst_load_value", 64'(load_value), 64'd0);
        chk("rst_cmd", 64'(proc2mem_command), 64'd0);
        chk("rst_addr", 64'(proc2mem_addr), 64'd0);
        chk("rst_data", proc2mem_data, 64'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            access(vecs[i].addr, vecs[i].sz, vecs[i].st, vecs[i].val, lv, h);
            chk($sformatf("vec%0d_hit", i), 64'(h), 64'(vecs[i].hit));
            chk($sformatf("vec%0d_lv", i), 64'(lv), 64'(vecs[i].lv));
        end

        // Writeback held off for two cycles, then stray tag ignored in WAIT.
        lsq_is_requesting = 1'b1;
        address = 32'h0000_2000;
        mem_size = 2'd2;
        is_store = 1'b0;
        value = '0;
        #1;
        chk("seqa_idle_completed", 64'(completed), 64'd0);
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("seqa_wb_cmd", 64'(proc2mem_command), 64'd2);
            chk("seqa_wb_addr", 64'(proc2mem_addr), 64'h1000);
            chk("seqa_wb_data", proc2mem_data, 64'hDEAD_BEEF_BEEF_A567);
            chk("seqa_wb_completed", 64'(completed), 64'd0);
            mem2proc_response = (i == 2) ? 4'd5 : 4'd0;
            @(negedge clock);
            mem2proc_response = '0;
        end
        mem[32'h1000] = 64'hDEAD_BEEF_BEEF_A567;
        #1;
        chk("seqa_fetch_cmd", 64'(proc2mem_command), 64'd1);
        chk("seqa_fetch_addr", 64'(proc2mem_addr), 64'h2000);
        mem2proc_response = 4'd2;
        @(negedge clock);
        mem2proc_response = '0;
        #1;
        chk("seqa_wait_cmd", 64'(proc2mem_command), 64'd0);
        mem2proc_tag = 4'd7;
        mem2proc_data = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge clock);
        mem2proc_tag = '0;
        #1;
        chk("seqa_wrong_tag_completed", 64'(completed), 64'd0);
        chk("seqa_wrong_tag_cmd", 64'(proc2mem_command), 64'd0);
        mem2proc_tag = 4'd2;
        mem2proc_data = mem_rd(32'h2000);
        @(negedge clock);
        mem2proc_tag = '0;
        #1;
        chk("seqa_fill_completed", 64'(completed), 64'd1);
        chk("seqa_fill_lv", 64'(load_value), 64'h5566_7788);
        cvalid[0] = 1'b1;
        ctag[0] = 24'h000020;
        @(negedge clock);
        lsq_is_requesting = 1'b0;

        // Request dropped while waiting for the fill.
        @(negedge clock);
        lsq_is_requesting = 1'b1;
        address = 32'h0000_3000;
        #1;
        chk("seqb_idle_completed", 64'(completed), 64'd0);
        @(negedge clock);
        #1;
        chk("seqb_fetch_cmd", 64'(proc2mem_command), 64'd1);
        chk("seqb_fetch_addr", 64'(proc2mem_addr), 64'h3000);
        mem2proc_response = 4'd4;
        @(negedge clock);
        mem2proc_response = '0;
        lsq_is_requesting = 1'b0;
        address = 32'h5555_0008;
        #1;
        chk("seqb_wait_cmd", 64'(proc2mem_command), 64'd0);
        mem2proc_tag = 4'd4;
        mem2proc_data = mem_rd(32'h3000);
        @(negedge clock);
        mem2proc_tag = '0;
        #1;
        chk("seqb_drop_completed", 64'(completed), 64'd0);
        chk("seqb_drop_cmd", 64'(proc2mem_command), 64'd0);
        cvalid[0] = 1'b1;
        ctag[0] = 24'h000030;
        access(32'h0000_3004, 2'd2, 1'b0, 32'h0, lv, h);
        chk("seqb_filled_hit", 64'(h), 64'd1);

        // Reset asserted while fetching, then a stray tag arrives.
        @(negedge clock);
        lsq_is_requesting = 1'b1;
        address = 32'h0000_4008;
        mem_size = 2'd2;
        is_store = 1'b0;
        @(negedge clock);
        #1;
        chk("seqc_fetch_cmd", 64'(proc2mem_command), 64'd1);
        chk("seqc_fetch_addr", 64'(proc2mem_addr), 64'h4008);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        lsq_is_requesting = 1'b0;
        #1;
        chk("seqc_rst_cmd", 64'(proc2mem_command), 64'd0);
        chk("seqc_rst_addr", 64'(proc2mem_addr), 64'd0);
        chk("seqc_rst_completed", 64'(completed), 64'd0);
        mem2proc_tag = 4'd6;
        mem2proc_data = 64'hFEED_FACE_CAFE_F00D;
        @(negedge clock);
        mem2proc_tag = '0;
        arch = mem;
        for (int i = 0; i < 32; i++) cvalid[i] = 1'b0;
        access(32'h0000_3000, 2'd2, 1'b0, 32'h0, lv, h);
        chk("seqc_after_rst_miss", 64'(h), 64'd0);
        access(32'h0000_4008, 2'd2, 1'b0, 32'h0, lv, h);
        chk("seqc_no_stray_fill", 64'(h), 64'd0);

        // Randomized accesses over a few conflicting tags.
        for (int n = 0; n < 300; n++) begin
            a = {22'h0, 2'($urandom_range(3, 0)), 5'($urandom_range(7, 0)),
                 3'($urandom_range(7, 0))};
            access(a, 2'($urandom_range(2, 0)), bit'($urandom_range(1, 0)), $urandom, lv, h);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
